// File: rtl/sdram_model_pkg.sv
// Shared types for the SDRAM device model: command codes, FSM states,
// violation codes and CAS-latency limits.
package sdram_model_pkg;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        INIT_PWRUP,
        INIT_PALL,
        INIT_REF1,
        INIT_REF2,
        INIT_READY
    } init_e;

    typedef enum logic {
        BANK_IDLE,
        BANK_OPEN
    } bank_e;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_INIT      = 3'd1;
    localparam logic [2:0] ERR_MRS       = 3'd2;
    localparam logic [2:0] ERR_ACT_OPEN  = 3'd3;
    localparam logic [2:0] ERR_BANK_IDLE = 3'd4;
    localparam logic [2:0] ERR_REF_OPEN  = 3'd5;
    localparam logic [2:0] ERR_WR_RD     = 3'd6;
    localparam logic [2:0] ERR_TIMING    = 3'd7;

    localparam int CL_MIN = 2;
    localparam int CL_MAX = 3;
    localparam int NBANK  = 4;
    localparam int TCW    = 4;

    typedef struct packed {
        logic        valid;
        logic [15:0] data;
    } rd_ent_t;

endpackage

// File: rtl/sdram_model_if.sv
// SDRAM pin bundle between the controller (master) and the device
// model (slave).
interface sdram_model_if;

    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        init_done;
    logic        err;
    logic [2:0]  err_code;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n,
        output ba, addr, dqm, dq_in,
        input  dq_out, dq_oe, init_done, err, err_code
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n,
        input  ba, addr, dqm, dq_in,
        output dq_out, dq_oe, init_done, err, err_code
    );

endinterface

// File: rtl/sdram_model_bank.sv
// One SDRAM bank: open flag, latched row and, with
// SDRAM_MODEL_TIMING_CHECK_EN, tRCD/tRP down-counters.
module sdram_model_bank
    import sdram_model_pkg::*;
#(
    parameter int T_RCD = 2,
    parameter int T_RP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cke_i,
    input  logic        act_i,
    input  logic        pre_i,
    input  logic [12:0] row_i,
    output logic        open_o,
    output logic [12:0] row_o,
    output logic        rcd_busy_o,
    output logic        rp_busy_o
);

    bank_e       st_q, st_d;
    logic [12:0] row_q, row_d;

    always_comb begin
        st_d  = st_q;
        row_d = row_q;
        if (cke_i) begin
            if (act_i) begin
                st_d  = BANK_OPEN;
                row_d = row_i;
            end else if (pre_i) begin
                st_d = BANK_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q  <= BANK_IDLE;
            row_q <= '0;
        end else begin
            st_q  <= st_d;
            row_q <= row_d;
        end
    end

    assign open_o = (st_q == BANK_OPEN);
    assign row_o  = row_q;

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    logic [TCW-1:0] rcd_q, rcd_d;
    logic [TCW-1:0] rp_q, rp_d;

    // Loaded with T-1 so a command exactly T cycles later sees zero
    always_comb begin
        rcd_d = rcd_q;
        rp_d  = rp_q;
        if (cke_i) begin
            if (rcd_q != '0) rcd_d = rcd_q - 1'b1;
            if (rp_q != '0)  rp_d  = rp_q - 1'b1;
            if (act_i)       rcd_d = TCW'(T_RCD - 1);
            if (pre_i)       rp_d  = TCW'(T_RP - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcd_q <= '0;
            rp_q  <= '0;
        end else begin
            rcd_q <= rcd_d;
            rp_q  <= rp_d;
        end
    end

    assign rcd_busy_o = (rcd_q != '0);
    assign rp_busy_o  = (rp_q != '0);
`else
    logic unused_tcfg;
    assign unused_tcfg = (T_RCD + T_RP) > 0;
    assign rcd_busy_o  = 1'b0;
    assign rp_busy_o   = 1'b0;
`endif

endmodule

// File: rtl/sdram_device_model.sv
// SDR SDRAM chip-side responder: decode, init FSM, storage, CL read pipe.
// Define SDRAM_MODEL_TIMING_CHECK_EN to enforce tRCD/tRP/tRC.
module sdram_device_model
    import sdram_model_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int T_RCD  = 2,
    parameter int T_RP   = 2,
    parameter int T_RC   = 7
) (
    input  logic          clk,
    input  logic          reset,
    sdram_model_if.slave  bus
);

    init_e       init_q, init_d;
    logic [2:0]  cl_q, cl_d;
    logic        err_q, err_d;
    logic [2:0]  code_q, code_d;
    logic        oe_q, oe_d;
    logic [15:0] dout_q, dout_d;
    rd_ent_t     pipe_q [CL_MAX];
    rd_ent_t     pipe_d [CL_MAX];

    cmd_e             cmd;
    logic             rdy, mrs_ok, pend, wr_en, drop, tviol;
    logic [2:0]       viol;
    logic [1:0]       ins;
    logic [NBANK-1:0] bsel, act_v, pre_v;
    logic [NBANK-1:0] bank_open, rcd_busy, rp_busy;
    logic [12:0]      bank_row [NBANK];

    logic [24:0]       idx_full;
    logic [MEM_AW-1:0] idx;
    logic [15:0]       mem [2**MEM_AW];
    logic [15:0]       rword, rdata;

    assign cmd    = bus.cs_n ? CMD_NOP
                  : cmd_e'({bus.ras_n, bus.cas_n, bus.we_n});
    assign rdy    = (init_q == INIT_READY);
    assign bsel   = NBANK'(1) << bus.ba;
    assign ins    = 2'(cl_q - 3'd1);
    assign mrs_ok = (bus.addr[6:4] >= 3'(CL_MIN))
                 && (bus.addr[6:4] <= 3'(CL_MAX))
                 && (bus.addr[2:0] == 3'b000);

    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < CL_MAX; i++) pend = pend | pipe_q[i].valid;
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        sdram_model_bank #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_bank (
            .clk        (clk),
            .reset      (reset),
            .cke_i      (bus.cke),
            .act_i      (act_v[b]),
            .pre_i      (pre_v[b]),
            .row_i      (bus.addr),
            .open_o     (bank_open[b]),
            .row_o      (bank_row[b]),
            .rcd_busy_o (rcd_busy[b]),
            .rp_busy_o  (rp_busy[b])
        );
    end

    // Full {ba,row,col} address folds onto the storage by truncation
    assign idx_full = {bus.ba, bank_row[bus.ba], bus.addr[9:0]};
    assign idx      = idx_full[MEM_AW-1:0];
    assign rword    = mem[idx];
    assign rdata    = {bus.dqm[1] ? 8'h00 : rword[15:8],
                       bus.dqm[0] ? 8'h00 : rword[7:0]};

    logic unused_hi;
    assign unused_hi = ^idx_full[24:MEM_AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!bus.dqm[0]) mem[idx][7:0]  <= bus.dq_in[7:0];
            if (!bus.dqm[1]) mem[idx][15:8] <= bus.dq_in[15:8];
        end
    end

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    logic [TCW-1:0] trc_q, trc_d;

    always_comb begin
        trc_d = trc_q;
        if (bus.cke) begin
            if (trc_q != '0)     trc_d = trc_q - 1'b1;
            if (cmd == CMD_REF)  trc_d = TCW'(T_RC - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) trc_q <= '0;
        else       trc_q <= trc_d;
    end

    always_comb begin
        tviol = 1'b0;
        if (cmd != CMD_NOP && trc_q != '0) tviol = 1'b1;
        if (cmd == CMD_ACT && rp_busy[bus.ba]) tviol = 1'b1;
        if ((cmd == CMD_RD || cmd == CMD_WR) && rcd_busy[bus.ba])
            tviol = 1'b1;
    end
`else
    logic unused_tcfg;
    assign unused_tcfg = (^{rcd_busy, rp_busy}) ^ (T_RC > 0);
    assign tviol       = 1'b0;
`endif

    always_comb begin
        init_d = init_q;
        cl_d   = cl_q;
        err_d  = err_q;
        code_d = code_q;
        oe_d   = oe_q;
        dout_d = dout_q;
        pipe_d = pipe_q;
        act_v  = '0;
        pre_v  = '0;
        wr_en  = 1'b0;
        drop   = 1'b0;
        viol   = ERR_NONE;
        if (bus.cke) begin
            for (int i = 0; i < CL_MAX - 1; i++) pipe_d[i] = pipe_q[i+1];
            pipe_d[CL_MAX-1] = '0;
            oe_d   = pipe_q[0].valid;
            dout_d = pipe_q[0].valid ? pipe_q[0].data : 16'h0000;
            unique case (cmd)
                CMD_NOP: ;
                CMD_MRS: begin
                    if (!rdy && init_q != INIT_REF2) viol = ERR_INIT;
                    else if (!mrs_ok) viol = ERR_MRS;
                    else begin
                        cl_d   = bus.addr[6:4];
                        init_d = INIT_READY;
                    end
                end
                CMD_REF: begin
                    unique case (init_q)
                        INIT_PALL:  init_d = INIT_REF1;
                        INIT_REF1:  init_d = INIT_REF2;
                        INIT_READY: if (|bank_open) viol = ERR_REF_OPEN;
                        default:    viol = ERR_INIT;
                    endcase
                end
                CMD_PRE: begin
                    if (init_q == INIT_PWRUP && bus.addr[10])
                        init_d = INIT_PALL;
                    else if (!rdy)
                        viol = ERR_INIT;
                    if (viol == ERR_NONE)
                        pre_v = bank_open
                              & (bus.addr[10] ? {NBANK{1'b1}} : bsel);
                end
                CMD_ACT: begin
                    if (!rdy) viol = ERR_INIT;
                    else if (bank_open[bus.ba]) viol = ERR_ACT_OPEN;
                    else act_v = bsel;
                end
                CMD_WR: begin
                    if (!rdy) viol = ERR_INIT;
                    else if (!bank_open[bus.ba]) viol = ERR_BANK_IDLE;
                    else begin
                        wr_en = 1'b1;
                        if (pend) begin
                            drop = 1'b1;
                            viol = ERR_WR_RD;
                        end
                        if (bus.addr[10]) pre_v = bsel;
                    end
                end
                CMD_RD: begin
                    if (!rdy) viol = ERR_INIT;
                    else if (!bank_open[bus.ba]) viol = ERR_BANK_IDLE;
                    else begin
                        pipe_d[ins] = {1'b1, rdata};
                        if (bus.addr[10]) pre_v = bsel;
                    end
                end
                CMD_BST: begin
                    if (!rdy) viol = ERR_INIT;
                    else drop = 1'b1;
                end
            endcase
            if (drop) begin
                for (int i = 0; i < CL_MAX; i++) pipe_d[i] = '0;
                oe_d   = 1'b0;
                dout_d = 16'h0000;
            end
            if (tviol && viol == ERR_NONE) viol = ERR_TIMING;
        end
        if (!err_q && viol != ERR_NONE) begin
            err_d  = 1'b1;
            code_d = viol;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_q <= INIT_PWRUP;
            cl_q   <= 3'(CL_MIN);
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            oe_q   <= 1'b0;
            dout_q <= '0;
            for (int i = 0; i < CL_MAX; i++) pipe_q[i] <= '0;
        end else begin
            init_q <= init_d;
            cl_q   <= cl_d;
            err_q  <= err_d;
            code_q <= code_d;
            oe_q   <= oe_d;
            dout_q <= dout_d;
            for (int i = 0; i < CL_MAX; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign bus.dq_out    = dout_q;
    assign bus.dq_oe     = oe_q;
    assign bus.init_done = rdy;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model; inputs change on the falling
// edge and outputs are sampled on the falling edge.
module tb_sdram_device_model;
    import sdram_model_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    sdram_model_if bus ();

    sdram_device_model dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b,
                       input logic [12:0] a, input logic [1:0] m,
                       input logic [15:0] d);
        bus.cs_n = 1'b0;
        {bus.ras_n, bus.cas_n, bus.we_n} = c;
        bus.ba    = b;
        bus.addr  = a;
        bus.dqm   = m;
        bus.dq_in = d;
        @(negedge clk);
        bus.cs_n = 1'b1;
        {bus.ras_n, bus.cas_n, bus.we_n} = 3'b111;
        bus.dqm  = 2'b00;
    endtask

    task automatic nop(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic init_seq(input logic [12:0] mrs);
        cmd(CMD_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        cmd(CMD_REF, 2'd0, 13'h000, 2'b00, 16'h0);
        nop(8);
        cmd(CMD_REF, 2'd0, 13'h000, 2'b00, 16'h0);
        nop(8);
        cmd(CMD_MRS, 2'd0, mrs, 2'b00, 16'h0);
    endtask

    // Read whose data must appear exactly cl cycles after the command
    task automatic rd_expect(input string tag, input logic [1:0] b,
                             input logic [12:0] a, input logic [1:0] m,
                             input int cl, input logic [15:0] exp);
        cmd(CMD_RD, b, a, m, 16'h0);
        repeat (cl) begin
            chk({tag, "_early_oe"}, 16'(bus.dq_oe), 16'd0);
            @(negedge clk);
        end
        chk({tag, "_oe"}, 16'(bus.dq_oe), 16'd1);
        chk({tag, "_data"}, bus.dq_out, exp);
        @(negedge clk);
        chk({tag, "_oe_drop"}, 16'(bus.dq_oe), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cke = 1'b1;
        bus.cs_n = 1'b1;
        {bus.ras_n, bus.cas_n, bus.we_n} = 3'b111;
        bus.ba = 2'd0;
        bus.addr = '0;
        bus.dqm = 2'b00;
        bus.dq_in = '0;
        nop(2);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_oe",   16'(bus.dq_oe), 16'd0);
        chk("rst_dq",   bus.dq_out, 16'h0000);
        chk("rst_init", 16'(bus.init_done), 16'd0);
        chk("rst_err",  16'(bus.err), 16'd0);
        chk("rst_code", 16'(bus.err_code), 16'd0);

        init_seq(13'h020);
        chk("init_done", 16'(bus.init_done), 16'd1);
        chk("init_err",  16'(bus.err), 16'd0);

        cmd(CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
        nop(2);
        cmd(CMD_WR, 2'd1, 13'h010, 2'b00, 16'hBEEF);
        rd_expect("rd_beef", 2'd1, 13'h010, 2'b00, 2, 16'hBEEF);

        cmd(CMD_WR, 2'd1, 13'h010, 2'b10, 16'h1234);
        rd_expect("rd_mask", 2'd1, 13'h010, 2'b00, 2, 16'hBE34);
        rd_expect("rd_dqm_lo", 2'd1, 13'h010, 2'b01, 2, 16'hBE00);

        cmd(CMD_MRS, 2'd0, 13'h030, 2'b00, 16'h0);
        rd_expect("rd_cl3", 2'd1, 13'h010, 2'b00, 3, 16'hBE34);

        cmd(CMD_WR, 2'd1, 13'h011, 2'b00, 16'h5A5A);
        cmd(CMD_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        cmd(CMD_RD, 2'd1, 13'h011, 2'b00, 16'h0);
        @(negedge clk);
        chk("b2b_early", 16'(bus.dq_oe), 16'd0);
        @(negedge clk);
        chk("b2b_oe0", 16'(bus.dq_oe), 16'd1);
        chk("b2b_d0",  bus.dq_out, 16'hBE34);
        @(negedge clk);
        chk("b2b_oe1", 16'(bus.dq_oe), 16'd1);
        chk("b2b_d1",  bus.dq_out, 16'h5A5A);
        @(negedge clk);
        chk("b2b_end", 16'(bus.dq_oe), 16'd0);

        cmd(CMD_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        cmd(CMD_BST, 2'd0, 13'h000, 2'b00, 16'h0);
        repeat (4) begin
            chk("bst_oe", 16'(bus.dq_oe), 16'd0);
            @(negedge clk);
        end
        chk("bst_err", 16'(bus.err), 16'd0);

        cmd(CMD_RD, 2'd2, 13'h000, 2'b00, 16'h0);
        chk("idle_err",  16'(bus.err), 16'd1);
        chk("idle_code", 16'(bus.err_code), 16'(ERR_BANK_IDLE));
        repeat (4) begin
            chk("idle_oe", 16'(bus.dq_oe), 16'd0);
            @(negedge clk);
        end
        cmd(CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
        chk("sticky_code", 16'(bus.err_code), 16'(ERR_BANK_IDLE));

        cmd(CMD_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        reset = 1'b1;
        #1;
        chk("arst_oe",   16'(bus.dq_oe), 16'd0);
        chk("arst_err",  16'(bus.err), 16'd0);
        chk("arst_init", 16'(bus.init_done), 16'd0);
        chk("arst_code", 16'(bus.err_code), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("arst_flush", 16'(bus.dq_oe), 16'd0);
        end

        init_seq(13'h020);
        cmd(CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
        nop(2);
        rd_expect("retained", 2'd1, 13'h010, 2'b00, 2, 16'hBE34);

        cmd(CMD_RD, 2'd1, 13'h012, 2'b00, 16'h0);
        cmd(CMD_WR, 2'd1, 13'h012, 2'b00, 16'h7777);
        chk("wrrd_err",  16'(bus.err), 16'd1);
        chk("wrrd_code", 16'(bus.err_code), 16'(ERR_WR_RD));
        @(negedge clk);
        chk("wrrd_drop", 16'(bus.dq_oe), 16'd0);
        nop(2);
        rd_expect("wrrd_wr", 2'd1, 13'h012, 2'b00, 2, 16'h7777);

        do_reset();
        cmd(CMD_ACT, 2'd0, 13'h000, 2'b00, 16'h0);
        chk("order_code", 16'(bus.err_code), 16'(ERR_INIT));
        chk("order_init", 16'(bus.init_done), 16'd0);

        do_reset();
        init_seq(13'h050);
        chk("mrs_bad_code", 16'(bus.err_code), 16'(ERR_MRS));
        chk("mrs_bad_init", 16'(bus.init_done), 16'd0);
        cmd(CMD_MRS, 2'd0, 13'h020, 2'b00, 16'h0);
        chk("mrs_ok_init", 16'(bus.init_done), 16'd1);
        chk("mrs_ok_code", 16'(bus.err_code), 16'(ERR_MRS));

        do_reset();
        init_seq(13'h020);
        cmd(CMD_ACT, 2'd0, 13'h001, 2'b00, 16'h0);
        rd_expect("trcd_rd", 2'd0, 13'h010, 2'b00, 2, 16'hBE34);
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
        chk("trcd_err",  16'(bus.err), 16'd1);
        chk("trcd_code", 16'(bus.err_code), 16'(ERR_TIMING));
`else
        chk("trcd_err",  16'(bus.err), 16'd0);
        chk("trcd_code", 16'(bus.err_code), 16'(ERR_NONE));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
